matrix_res_serializer: RTL and testbench
========================================

Name: matrix_res_serializer

Overview:
- Downstream end of the 2x2 matrix datapath.
- Accepts 32-bit packed 2x2 matrices (four 8-bit elements, row-major, element 0 in bits [31:24]) from the matrix unit's result port and buffers them in a 2-entry FIFO.
- Emits the elements one per handshake on an 8-bit stream with index and last-element flag.
- Performs the inverse of the packing the operand side uses: {8'd1,8'd2,8'd3,8'd4} streams out as 1, 2, 3, 4.

Parameters:
- ELEM_W, 8, element width in bits; the packed word is 4*ELEM_W.
- DEPTH, 2, word FIFO depth; power of two, >= 2.
- CNT_W, 8, width of the frame counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  4*ELEM_W  packed matrix {m00,m01,m10,m11}.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- out_data  output  ELEM_W  current element.
- out_idx  output  2  element index 0..3 (m00, m01, m10, m11).
- out_last  output  1  high with element 3 of each matrix.
- out_valid  output  1  out_data, out_idx and out_last are valid.
- out_ready  input  1  consumer accepts the element.
- frames_out  output  CNT_W  count of fully emitted matrices; wraps.

Behaviour:
- Reset (rst low, asynchronous):
  - FIFO pointers and count cleared; idx = 0; frames_out = 0.
  - out_valid = 0, out_last = 0, out_idx = 0, out_data = 0.
  - in_ready = 0 while rst is low.
  - After release, in_ready = 1 from the first cycle.
- Input push: on a rising edge with in_valid & in_ready, in_data is written at the write pointer, which advances modulo DEPTH.
- in_ready = rst & (count != DEPTH). It depends only on the registered count; a same-cycle pop does not raise it (no pass-through).
- Two states:
  - EMPTY: count == 0, out_valid = 0.
  - STREAM: count > 0, out_valid = 1.
  - Outputs are combinational from the head word and the idx register.
- Output mapping:
  - out_data = head[(3-idx)*ELEM_W +: ELEM_W].
  - out_idx = idx.
  - out_last = out_valid & (idx == 3).
  - When out_valid = 0, out_data is forced to 0.
- Latency: a word accepted at edge N gives out_valid = 1 after edge N (visible in cycle N+1) when the FIFO was empty. Best case is 4 cycles per matrix with out_ready held high.
- Output handshake, on a rising edge with out_valid & out_ready:
  - If idx < 3: idx increments.
  - If idx == 3: idx returns to 0, the head word is popped (read pointer advances, count decrements), and frames_out increments.
- Stall: with out_ready low, out_data, out_idx, out_last and out_valid hold stable; an accepted element is never dropped or repeated.
- Simultaneous push and pop in the same edge: count is unchanged and both pointers advance. This is legal whenever count < DEPTH.
- Full: count == DEPTH, in_ready = 0. in_valid is ignored, and the upstream holds in_data.
- Empty: out_valid = 0 and idx stays 0; out_ready is ignored.
- frames_out wraps from 2^CNT_W-1 to 0 without flagging.
- Reset mid-operation: a partially emitted matrix and all buffered words are discarded, and the stream restarts at idx 0 with the next accepted word.
- Arithmetic: pointers are log2(DEPTH) bits; count is log2(DEPTH)+1 bits.

Test Plan:
- Single word {8'd1,8'd2,8'd3,8'd4}, out_ready held 1 -> out_data 1,2,3,4 on 4 consecutive cycles; out_idx 0..3; out_last only with 4; frames_out 0->1; then out_valid = 0.
- Back-to-back words {5,6,7,8}, {19,22,43,50} presented every cycle, out_ready 1 -> in_ready drops to 0 after 2 accepts while the first word drains; the stream is 5,6,7,8,19,22,43,50 with no gaps; frames_out = 2.
- out_ready toggled 1,0,0,1 on word {8'hAA,8'hBB,8'hCC,8'hDD} -> each byte held stable during stalls; the sequence is AA,BB,CC,DD exactly once each.
- FIFO full (2 words, out_ready 0), third word offered -> in_ready = 0; the third word is accepted only after the first word's out_last handshake.
- Assert rst low after element 1 of {1,2,3,4} -> outputs go to 0 immediately, without waiting for clk; after release a new word {9,10,11,12} streams from idx 0.
- 256 matrices streamed -> frames_out wraps to 0 and the data stream remains correct.

Source files
------------

// File: rtl/matrix_res_serializer.sv
`default_nettype none
// ============================================================================
// Module   : matrix_res_serializer
// Brief    : Buffers packed 2x2 matrices in a small FIFO and streams them out
//            one element per handshake with index and last-element flag.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_res_serializer #(
    parameter int ELEM_W = 8,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*ELEM_W-1:0]   in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ELEM_W-1:0]     out_data,
    output logic [1:0]            out_idx,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      frames_out
);

    localparam int               PTR_W       = $clog2(DEPTH);
    localparam logic [PTR_W:0]   c_FULL      = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   c_CNT_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] c_PTR_ONE   = (PTR_W)'(1);
    localparam logic [0:0]       c_ST_EMPTY  = 1'b0;
    localparam logic [0:0]       c_ST_STREAM = 1'b1;

    logic [4*ELEM_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    r_rptr;
    logic [PTR_W:0]      r_count;
    logic [1:0]          r_idx;
    logic [CNT_W-1:0]    r_frames;
    logic [0:0]          r_state;

    logic [0:0]          w_state_next;
    logic [PTR_W:0]      w_count_next;
    logic                w_push;
    logic                w_fire;
    logic                w_pop;
    logic [4*ELEM_W-1:0] w_head;
    logic [1:0]          w_sel;

    // in_ready looks only at the registered count: a pop in the same cycle
    // does not open a slot until the next cycle.
    assign in_ready = rst & (r_count != c_FULL);
    assign w_push   = in_valid & in_ready;
    assign w_fire   = out_valid & out_ready;
    assign w_pop    = w_fire & (r_idx == 2'd3);
    assign w_head   = r_mem[r_rptr];
    assign w_sel    = 2'd3 - r_idx;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + c_CNT_ONE;
            2'b01:   w_count_next = r_count - c_CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    // Word storage needs no reset; contents are only observed while count > 0.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_idx    <= 2'd0;
            r_frames <= '0;
        end else begin
            r_count <= w_count_next;
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_fire) begin
                if (r_idx == 2'd3) begin
                    r_idx    <= 2'd0;
                    r_rptr   <= r_rptr + c_PTR_ONE;
                    r_frames <= r_frames + CNT_W'(1);
                end else begin
                    r_idx <= r_idx + 2'd1;
                end
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state follows the occupancy after this edge
    always_comb begin
        w_state_next = c_ST_EMPTY;
        if (w_count_next != '0) begin
            w_state_next = c_ST_STREAM;
        end
    end

    // FSM: outputs
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_idx   = r_idx;
        out_last  = 1'b0;
        if (r_state == c_ST_STREAM) begin
            out_valid = 1'b1;
            out_data  = w_head[int'(w_sel)*ELEM_W +: ELEM_W];
            out_last  = (r_idx == 2'd3);
        end
    end

    assign frames_out = r_frames;

endmodule
`default_nettype wire

// File: tb/tb_matrix_res_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_res_serializer
// Brief    : Directed scoreboard bench for matrix_res_serializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_res_serializer;

    localparam int ELEM_W = 8;
    localparam int DEPTH  = 2;
    localparam int CNT_W  = 8;

    logic                clk;
    logic                rst;
    logic [4*ELEM_W-1:0] in_data;
    logic                in_valid;
    logic                in_ready;
    logic [ELEM_W-1:0]   out_data;
    logic [1:0]          out_idx;
    logic                out_last;
    logic                out_valid;
    logic                out_ready;
    logic [CNT_W-1:0]    frames_out;

    matrix_res_serializer #(
        .ELEM_W (ELEM_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frames_out (frames_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected element entries: {last, idx[1:0], data[7:0]}
    logic [10:0]      sb[$];
    logic [7:0]       pend[4];
    logic [CNT_W-1:0] frames_mdl;
    logic             acc;
    int               n_vec;
    int               n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: called at a falling edge with inputs already driven.
    task automatic step();
        int          words;
        logic [10:0] e;
        #1;
        words = (sb.size() + 3) / 4;
        acc   = 1'b0;
        chk("in_ready", 32'(in_ready), 32'(words != DEPTH));
        chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        if (out_valid && sb.size() != 0) begin
            e = sb[0];
            chk("element", 32'({out_last, out_idx, out_data}), 32'(e));
            if (out_ready) begin
                void'(sb.pop_front());
                if (e[10]) frames_mdl = frames_mdl + 1'b1;
            end
        end else if (!out_valid) begin
            chk("idle_outputs", 32'({out_last, out_idx, out_data}), 32'd0);
        end
        if (in_valid && in_ready) begin
            acc = 1'b1;
            for (int k = 0; k < 4; k++) begin
                sb.push_back({(k == 3), k[1:0], pend[k]});
            end
        end
        @(negedge clk);
        chk("frames_out", 32'(frames_out), 32'(frames_mdl));
    endtask

    // Presents a word and keeps in_valid high until it is taken.
    task automatic send(input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3);
        int n;
        pend[0] = b0; pend[1] = b1; pend[2] = b2; pend[3] = b3;
        in_data  = {b0, b1, b2, b3};
        in_valid = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while (sb.size() != 0 && n < max) begin
            step();
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
        step();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_outputs", 32'({out_valid, out_last, out_idx, out_data}), 32'd0);
        sb.delete();
        frames_mdl = '0;
        in_valid   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_frames", 32'(frames_out), 32'd0);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec      = 0;
        n_err      = 0;
        frames_mdl = '0;
        acc        = 1'b0;
        rst        = 1'b0;
        in_data    = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        @(negedge clk);
        do_reset();

        // Single word, consumer always ready
        out_ready = 1'b1;
        send(8'd1, 8'd2, 8'd3, 8'd4);
        in_valid = 1'b0;
        drain(20);
        chk("single_frames", 32'(frames_out), 32'd1);

        // Back-to-back words with no gaps
        send(8'd5, 8'd6, 8'd7, 8'd8);
        send(8'd19, 8'd22, 8'd43, 8'd50);
        in_valid = 1'b0;
        drain(20);
        chk("b2b_frames", 32'(frames_out), 32'd3);

        // Consumer stalls
        send(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            out_ready = (i % 4 == 0) || (i % 4 == 3);
            step();
        end
        out_ready = 1'b1;
        drain(20);

        // Fill the FIFO, then offer a third word
        out_ready = 1'b0;
        send(8'd11, 8'd12, 8'd13, 8'd14);
        send(8'd21, 8'd22, 8'd23, 8'd24);
        pend[0] = 8'd31; pend[1] = 8'd32; pend[2] = 8'd33; pend[3] = 8'd34;
        in_data  = {8'd31, 8'd32, 8'd33, 8'd34};
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) step();
        out_ready = 1'b1;
        send(8'd31, 8'd32, 8'd33, 8'd34);
        in_valid = 1'b0;
        drain(40);

        // Asynchronous reset mid-frame
        send(8'd1, 8'd2, 8'd3, 8'd4);
        in_valid = 1'b0;
        step();
        do_reset();
        send(8'd9, 8'd10, 8'd11, 8'd12);
        in_valid = 1'b0;
        drain(20);
        chk("post_reset_frames", 32'(frames_out), 32'd1);

        // Frame counter wrap
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            send(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end
        in_valid = 1'b0;
        drain(40);
        chk("wrap_frames", 32'(frames_out), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
